// File: rtl/key_cmd_queue.sv
// key_cmd_queue: turns key-held levels into 3-bit commands, adds typematic
// auto-repeat on held arrow keys, and buffers commands in a small FIFO with a
// valid/ready handshake towards the game FSM.
//
// Repeat FSM states
//   state    | meaning
//   S_IDLE   | no arrow held (or released), counter ignored
//   S_DELAY  | arrow held, waiting out the initial repeat delay
//   S_REPEAT | arrow still held, emitting repeats every REPEAT_RATE cycles
module key_cmd_queue #(
  parameter int FIFO_DEPTH   = 4,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          up,
  input  logic                          down,
  input  logic                          left,
  input  logic                          right,
  input  logic                          space,
  input  logic                          restart,
  input  logic                          quit,
  input  logic                          select,
  output logic [2:0]                    cmd_data,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int REP_MAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW        = $clog2(REP_MAX);
  localparam logic [CW-1:0] DELAY_LOAD = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LOAD  = CW'(REPEAT_RATE - 1);
  localparam logic [AW:0]   FULL_CNT   = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

  // Bit index equals the command code.
  logic [7:0]    keys;
  logic [7:0]    prev;
  logic [7:0]    press;
  logic          press_valid;
  logic [2:0]    press_code;
  logic          arrow_press;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    rep_code;
  logic          held;
  logic          rep_fire;

  logic          ev_valid;
  logic [2:0]    ev_code;

  logic [2:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          push;
  logic          pop;

  assign keys  = {select, quit, restart, space, right, left, down, up};
  assign press = keys & ~prev;

  // Pick the single winning press among simultaneous rising keys.
  always_comb begin
    press_valid = 1'b1;
    press_code  = 3'd0;
    if      (press[6]) press_code = 3'd6;
    else if (press[5]) press_code = 3'd5;
    else if (press[7]) press_code = 3'd7;
    else if (press[4]) press_code = 3'd4;
    else if (press[0]) press_code = 3'd0;
    else if (press[1]) press_code = 3'd1;
    else if (press[2]) press_code = 3'd2;
    else if (press[3]) press_code = 3'd3;
    else               press_valid = 1'b0;
  end

  assign arrow_press = press_valid && !press_code[2];
  assign held        = keys[{1'b0, rep_code}];
  // A new arrow press restarts the delay, so it suppresses any repeat due this cycle.
  assign rep_fire    = (state != S_IDLE) && !arrow_press && held && (cnt == '0);

  // Key history for rising-edge detection.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) prev <= '0;
    else       prev <= keys;
  end

  // Typematic repeat FSM with down-counter; reloads even when a press wins the merge.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rep_code <= '0;
    end else if (arrow_press) begin
      rep_code <= press_code[1:0];
      cnt      <= DELAY_LOAD;
      state    <= S_DELAY;
    end else begin
      case (state)
        S_DELAY, S_REPEAT: begin
          if (!held) begin
            state <= S_IDLE;
          end else if (cnt == '0) begin
            cnt   <= RATE_LOAD;
            state <= S_REPEAT;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Register the merged event; a press beats a repeat in the same cycle.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      ev_valid <= 1'b0;
      ev_code  <= '0;
    end else begin
      ev_valid <= press_valid || rep_fire;
      ev_code  <= press_valid ? press_code : {1'b0, rep_code};
    end
  end

  assign full = (count == FULL_CNT);
  assign pop  = (count != '0) && cmd_ready;
  assign push = ev_valid && (!full || pop);

  // FIFO storage.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= ev_code;
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (ev_valid && full && !pop) overflow <= 1'b1;
    end
  end

  assign cmd_valid  = (count != '0);
  assign cmd_data   = cmd_valid ? mem[rd_ptr] : 3'd0;
  assign fifo_count = count;

endmodule

// File: tb/tb_key_cmd_queue.sv
// tb_key_cmd_queue: directed vector table for single-cycle behaviour plus
// hand-written sequences for repeat timing, full-FIFO push/pop and reset.
module tb_key_cmd_queue;

  localparam logic [7:0] K_UP      = 8'h01;
  localparam logic [7:0] K_DOWN    = 8'h02;
  localparam logic [7:0] K_LEFT    = 8'h04;
  localparam logic [7:0] K_RIGHT   = 8'h08;
  localparam logic [7:0] K_SPACE   = 8'h10;
  localparam logic [7:0] K_RESTART = 8'h20;
  localparam logic [7:0] K_QUIT    = 8'h40;
  localparam logic [7:0] K_SELECT  = 8'h80;

  logic       CLOCK_50;
  logic       reset;
  logic       up, down, left, right, space, restart, quit, select;
  logic [2:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       overflow;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [7:0] keys;
    logic       ready;
    logic       exp_valid;
    logic [2:0] exp_data;
    logic [2:0] exp_count;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  key_cmd_queue #(
    .FIFO_DEPTH  (4),
    .REPEAT_DELAY(10),
    .REPEAT_RATE (4)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .space     (space),
    .restart   (restart),
    .quit      (quit),
    .select    (select),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .overflow  (overflow),
    .fifo_count(fifo_count)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic void add(input logic r, input logic [7:0] k, input logic rd,
                              input logic v, input logic [2:0] d, input logic [2:0] c,
                              input logic o);
    vec_t e;
    e.rst = r; e.keys = k; e.ready = rd;
    e.exp_valid = v; e.exp_data = d; e.exp_count = c; e.exp_ovf = o;
    vecs.push_back(e);
  endfunction

  task automatic drive_keys(input logic [7:0] k);
    {select, quit, restart, space, right, left, down, up} = k;
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_keys(8'h00);
    cmd_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Hold left 30 cycles: entries at offsets 1,11,15,19,23,27; nothing after release.
  task automatic test_repeat();
    logic exp_v;
    do_reset();
    cmd_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      drive_keys(i < 30 ? K_LEFT : 8'h00);
      tick();
      exp_v = (i == 1) || (i == 11) || (i == 15) || (i == 19) || (i == 23) || (i == 27);
      chk($sformatf("repeat valid t%0d", i), 32'(cmd_valid), 32'(exp_v));
      if (exp_v) chk($sformatf("repeat data t%0d", i), 32'(cmd_data), 32'd2);
    end
  endtask

  // Full FIFO, pop and push on the same edge: count stays 4, no overflow, order kept.
  task automatic test_full_pushpop();
    logic [7:0] seq [4];
    seq[0] = K_UP; seq[1] = K_DOWN; seq[2] = K_LEFT; seq[3] = K_RIGHT;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_keys(seq[i]);
      tick();
      drive_keys(8'h00);
      tick();
    end
    chk("full count", 32'(fifo_count), 32'd4);
    drive_keys(K_SPACE);
    tick();
    drive_keys(8'h00);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("pushpop count", 32'(fifo_count), 32'd4);
    chk("pushpop overflow", 32'(overflow), 32'd0);
    chk("pushpop head", 32'(cmd_data), 32'd1);
    cmd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("drain head %0d", i), 32'(cmd_data), 32'(i + 2));
      chk($sformatf("drain count %0d", i), 32'(fifo_count), 32'(2 - i + 1));
    end
    tick();
    chk("drain empty", 32'(cmd_valid), 32'd0);
    chk("drain overflow", 32'(overflow), 32'd0);
    cmd_ready = 1'b0;
  endtask

  // Reset in the middle of a right-arrow delay, key still held across release.
  task automatic test_reset_mid();
    do_reset();
    drive_keys(K_RIGHT);
    for (int i = 0; i < 5; i++) tick();
    chk("pre-reset count", 32'(fifo_count), 32'd1);
    chk("pre-reset data", 32'(cmd_data), 32'd3);
    #3;
    reset = 1'b1;
    #1;
    chk("async valid", 32'(cmd_valid), 32'd0);
    chk("async count", 32'(fifo_count), 32'd0);
    chk("async data", 32'(cmd_data), 32'd0);
    for (int i = 0; i < 12; i++) tick();
    chk("in-reset count", 32'(fifo_count), 32'd0);
    reset = 1'b0;
    tick();
    chk("post-reset edge1 count", 32'(fifo_count), 32'd0);
    tick();
    chk("post-reset edge2 count", 32'(fifo_count), 32'd1);
    chk("post-reset data", 32'(cmd_data), 32'd3);
    drive_keys(8'h00);
    for (int i = 0; i < 3; i++) tick();
    chk("post-reset final count", 32'(fifo_count), 32'd1);
    chk("post-reset overflow", 32'(overflow), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cmd_ready = 1'b0;
    drive_keys(8'h00);

    // Single short up press, consumer always ready.
    add(1, 8'h00, 1, 0, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0, 0);
    add(0, K_UP,  1, 0, 0, 0, 0);
    add(0, K_UP,  1, 1, 0, 1, 0);
    add(0, K_UP,  1, 0, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0, 0);

    // Five presses into a four-deep FIFO with the consumer stalled, then drain.
    add(1, 8'h00,   0, 0, 0, 0, 0);
    add(0, K_UP,    0, 0, 0, 0, 0);
    add(0, 8'h00,   0, 1, 0, 1, 0);
    add(0, K_DOWN,  0, 1, 0, 1, 0);
    add(0, 8'h00,   0, 1, 0, 2, 0);
    add(0, K_LEFT,  0, 1, 0, 2, 0);
    add(0, 8'h00,   0, 1, 0, 3, 0);
    add(0, K_RIGHT, 0, 1, 0, 3, 0);
    add(0, 8'h00,   0, 1, 0, 4, 0);
    add(0, K_SPACE, 0, 1, 0, 4, 0);
    add(0, 8'h00,   0, 1, 0, 4, 1);
    add(0, 8'h00,   0, 1, 0, 4, 1);
    add(0, 8'h00,   1, 1, 1, 3, 1);
    add(0, 8'h00,   1, 1, 2, 2, 1);
    add(0, 8'h00,   1, 1, 3, 1, 1);
    add(0, 8'h00,   1, 0, 0, 0, 1);
    add(0, 8'h00,   1, 0, 0, 0, 1);

    // Quit and up together: only quit, and no up repeat while both stay held.
    add(1, 8'h00, 0, 0, 0, 0, 0);
    add(0, K_QUIT | K_UP, 0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) add(0, K_QUIT | K_UP, 0, 1, 6, 1, 0);
    add(0, 8'h00, 0, 1, 6, 1, 0);
    add(0, K_RESTART | K_SELECT | K_SPACE, 0, 1, 6, 1, 0);
    add(0, 8'h00, 0, 1, 6, 2, 0);
    add(0, 8'h00, 1, 1, 5, 1, 0);
    add(0, 8'h00, 1, 0, 0, 0, 0);

    // Space beats up; down beats right.
    add(1, 8'h00, 0, 0, 0, 0, 0);
    add(0, K_SPACE | K_UP, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 1, 4, 1, 0);
    add(0, K_DOWN | K_RIGHT, 0, 1, 4, 1, 0);
    add(0, 8'h00, 0, 1, 4, 2, 0);
    add(0, 8'h00, 1, 1, 1, 1, 0);
    add(0, 8'h00, 1, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst;
      drive_keys(vecs[i].keys);
      cmd_ready = vecs[i].ready;
      tick();
      chk($sformatf("vec%0d valid", i), 32'(cmd_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d data", i), 32'(cmd_data), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d count", i), 32'(fifo_count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
    end

    test_repeat();
    test_full_pushpop();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
